// File: rtl/trng_pkg.sv
// Shared types and defaults for the entropy health-test block.
// Holds the FSM state encoding, failure codes, word width and default cutoffs.
package trng_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned RCT_C_DEF = 32;
    localparam int unsigned APT_W_DEF = 1024;
    localparam int unsigned APT_C_DEF = 840;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        STARTUP = 2'b01,
        RUN     = 2'b10,
        FAIL    = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE = 2'b00,
        FC_RCT  = 2'b01,
        FC_APT  = 2'b10,
        FC_BOTH = 2'b11
    } fail_code_t;

endpackage

// File: rtl/health_apt.sv
// Adaptive-proportion test: counts occurrences of each window's first bit and
// flags (combinationally, on the offending sample) when the count reaches APT_C.
module health_apt
    import trng_pkg::*;
#(
    parameter int unsigned APT_W = APT_W_DEF,
    parameter int unsigned APT_C = APT_C_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic sample,
    input  logic valid,
    output logic fail
);

    localparam int unsigned WW = $clog2(APT_W + 1);
    localparam int unsigned CW = $clog2(APT_C + 1);

    logic [WW-1:0] win_cnt;
    logic [CW-1:0] hit_cnt;
    logic [CW-1:0] hit_nxt;
    logic          ref_bit;
    logic          new_win;
    logic          match;

    // A cleared counter and a completed window both mean the sample opens a new window.
    always_comb begin
        new_win = (win_cnt == '0) || (win_cnt == WW'(APT_W));
        match   = new_win || (sample == ref_bit);
        hit_nxt = hit_cnt;
        if (new_win)
            hit_nxt = CW'(1);
        else if (match && (hit_cnt != CW'(APT_C)))
            hit_nxt = hit_cnt + CW'(1);
        fail = valid && match && (hit_nxt == CW'(APT_C));
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            win_cnt <= '0;
            hit_cnt <= '0;
            ref_bit <= 1'b0;
        end else if (valid) begin
            win_cnt <= new_win ? WW'(1) : win_cnt + WW'(1);
            hit_cnt <= hit_nxt;
            if (new_win)
                ref_bit <= sample;
        end
    end

endmodule

// File: rtl/entropy_health.sv
// Raw entropy health monitor (RCT + APT) with LSB-first 32-bit word packing.
// Define HEALTH_STATS_EN to add drop_cnt / fail_cnt statistics outputs.
module entropy_health
    import trng_pkg::*;
#(
    parameter int unsigned RCT_C = RCT_C_DEF,
    parameter int unsigned APT_W = APT_W_DEF,
    parameter int unsigned APT_C = APT_C_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              raw_bit,
    input  logic              raw_vld,
    output logic [WORD_W-1:0] word_out,
    output logic              word_vld,
    input  logic              word_rdy,
    output logic              fail,
    output logic [1:0]        fail_code,
    input  logic              clr_fail
`ifdef HEALTH_STATS_EN
    ,
    output logic [7:0]        drop_cnt,
    output logic [7:0]        fail_cnt
`endif
);

    localparam int unsigned RW = $clog2(RCT_C + 1);
    localparam int unsigned SW = $clog2(APT_W + 1);
    localparam int unsigned IW = $clog2(WORD_W);

    state_t            state, state_nxt;
    fail_code_t        fc_q;
    logic [RW-1:0]     run_cnt, run_nxt;
    logic              prev_bit;
    logic [SW-1:0]     su_cnt;
    logic [IW-1:0]     bit_idx;
    logic [WORD_W-1:0] shifter, word_nxt;

    logic tst_vld, rct_fail, apt_fail, any_fail;
    logic word_done, load, handshake;
    logic enter_fail, restart, ctr_clr;

    assign tst_vld   = raw_vld && en && ((state == STARTUP) || (state == RUN));
    assign handshake = word_vld && word_rdy;
    assign fail_code = fc_q;

    always_comb begin
        run_nxt = run_cnt;
        if ((run_cnt == '0) || (raw_bit != prev_bit))
            run_nxt = RW'(1);
        else if (run_cnt != RW'(RCT_C))
            run_nxt = run_cnt + RW'(1);
        rct_fail = tst_vld && (run_nxt == RW'(RCT_C));
        any_fail = rct_fail || apt_fail;
    end

    health_apt #(
        .APT_W (APT_W),
        .APT_C (APT_C)
    ) u_apt (
        .clk    (clk),
        .rst    (rst),
        .clr    (ctr_clr),
        .sample (raw_bit),
        .valid  (tst_vld),
        .fail   (apt_fail)
    );

    always_comb begin
        word_nxt          = shifter;
        word_nxt[bit_idx] = raw_bit;
        word_done         = tst_vld && (state == RUN) && (bit_idx == IW'(WORD_W - 1));
        load              = word_done && !any_fail && (!word_vld || word_rdy);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = STARTUP;
            STARTUP: begin
                if (!en)
                    state_nxt = IDLE;
                else if (any_fail)
                    state_nxt = FAIL;
                else if (tst_vld && (su_cnt == SW'(APT_W - 1)))
                    state_nxt = RUN;
            end
            RUN: begin
                if (!en)
                    state_nxt = IDLE;
                else if (any_fail)
                    state_nxt = FAIL;
            end
            FAIL:    if (clr_fail) state_nxt = STARTUP;
            default: state_nxt = IDLE;
        endcase
        enter_fail = (state_nxt == FAIL) && (state != FAIL);
        restart    = (state == FAIL) && clr_fail;
        ctr_clr    = restart || (state_nxt == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            run_cnt  <= '0;
            prev_bit <= 1'b0;
            su_cnt   <= '0;
            bit_idx  <= '0;
            shifter  <= '0;
            word_out <= '0;
            word_vld <= 1'b0;
            fail     <= 1'b0;
            fc_q     <= FC_NONE;
        end else begin
            state <= state_nxt;

            if (ctr_clr) begin
                run_cnt  <= '0;
                prev_bit <= 1'b0;
                su_cnt   <= '0;
                bit_idx  <= '0;
                shifter  <= '0;
            end else if (enter_fail) begin
                bit_idx <= '0;
                shifter <= '0;
            end else if (tst_vld) begin
                run_cnt  <= run_nxt;
                prev_bit <= raw_bit;
                if (state == STARTUP) begin
                    su_cnt <= su_cnt + SW'(1);
                end else begin
                    bit_idx <= bit_idx + IW'(1);
                    shifter <= word_done ? '0 : word_nxt;
                end
            end

            // A failure squashes any held word so it can never be delivered.
            if (enter_fail) begin
                word_vld <= 1'b0;
            end else if (load) begin
                word_out <= word_nxt;
                word_vld <= 1'b1;
            end else if (handshake) begin
                word_vld <= 1'b0;
            end

            if (enter_fail) begin
                fail <= 1'b1;
                fc_q <= fail_code_t'({apt_fail, rct_fail});
            end else if (restart) begin
                fail <= 1'b0;
                fc_q <= FC_NONE;
            end
        end
    end

`ifdef HEALTH_STATS_EN
    logic drop;
    assign drop = word_done && !any_fail && !load;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
            fail_cnt <= '0;
        end else begin
            if (drop && (drop_cnt != '1))
                drop_cnt <= drop_cnt + 8'd1;
            if (enter_fail && (fail_cnt != '1))
                fail_cnt <= fail_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_entropy_health.sv
// Scoreboard bench for entropy_health: stimulus pushes expected words, a
// negedge monitor pops and compares on every word handshake.
module tb_entropy_health;

    logic        clk = 1'b0;
    logic        rst, en, raw_bit, raw_vld, word_rdy, clr_fail;
    logic [31:0] word_out;
    logic        word_vld, fail;
    logic [1:0]  fail_code;
`ifdef HEALTH_STATS_EN
    logic [7:0]  drop_cnt, fail_cnt;
`endif

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    entropy_health #(
        .RCT_C (32),
        .APT_W (1024),
        .APT_C (840)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .raw_bit   (raw_bit),
        .raw_vld   (raw_vld),
        .word_out  (word_out),
        .word_vld  (word_vld),
        .word_rdy  (word_rdy),
        .fail      (fail),
        .fail_code (fail_code),
        .clr_fail  (clr_fail)
`ifdef HEALTH_STATS_EN
        ,
        .drop_cnt  (drop_cnt),
        .fail_cnt  (fail_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (word_vld === 1'b1 && word_rdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_word: got 0x%08h expected none", word_out);
            end else begin
                check("word", word_out, exp_q.pop_front());
            end
        end
    end

    task automatic cycles(input int n);
        raw_vld = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        raw_bit = b;
        raw_vld = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic startup_seq();
        for (int i = 0; i < 1024; i++)
            send_bit((i % 2) == 0);
        raw_vld = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic rdy_on_last);
        for (int i = 0; i < 32; i++) begin
            if (i == 31 && rdy_on_last)
                word_rdy = 1'b1;
            send_bit(w[i]);
        end
        raw_vld = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; raw_bit = 1'b0; raw_vld = 1'b0;
        word_rdy = 1'b1; clr_fail = 1'b0;
        cycles(3);
        check("rst_word_out", word_out, 32'h0);
        check("rst_word_vld", {31'b0, word_vld}, 32'h0);
        check("rst_fail", {31'b0, fail}, 32'h0);
        check("rst_fail_code", {30'b0, fail_code}, 32'h0);
        rst = 1'b0;
        en  = 1'b1;
        cycles(2);

        // startup then first packed word
        startup_seq();
        exp_q.push_back(32'hA5A5A5A5);
        send_word(32'hA5A5A5A5, 1'b1);
        check("first_word_latency", {31'b0, word_vld}, 32'h1);
        check("first_word_value", word_out, 32'hA5A5A5A5);
        check("startup_no_fail", {31'b0, fail}, 32'h0);
        cycles(1);

        // back-to-back: held word consumed in the cycle the next one loads
        word_rdy = 1'b0;
        exp_q.push_back(32'h12345678);
        send_word(32'h12345678, 1'b0);
        check("held_vld", {31'b0, word_vld}, 32'h1);
        exp_q.push_back(32'h9ABCDEF0);
        send_word(32'h9ABCDEF0, 1'b1);
        check("b2b_vld", {31'b0, word_vld}, 32'h1);
        check("b2b_value", word_out, 32'h9ABCDEF0);
        cycles(1);
        check("vld_fall_after_hs", {31'b0, word_vld}, 32'h0);

        // hold first word, drop second
        word_rdy = 1'b0;
        exp_q.push_back(32'hCAFEBABE);
        send_word(32'hCAFEBABE, 1'b0);
        send_word(32'hDEADBEEF, 1'b0);
        check("drop_keeps_held", word_out, 32'hCAFEBABE);
`ifdef HEALTH_STATS_EN
        check("drop_cnt", {24'b0, drop_cnt}, 32'h1);
`endif
        word_rdy = 1'b1;
        cycles(2);

        // reset mid-word
        for (int i = 0; i < 17; i++)
            send_bit(i[0]);
        rst = 1'b1;
        send_bit(1'b1);
        rst = 1'b0;
        check("midrst_word_out", word_out, 32'h0);
        check("midrst_word_vld", {31'b0, word_vld}, 32'h0);
        check("midrst_fail", {30'b0, fail_code, fail}, 32'h0);
`ifdef HEALTH_STATS_EN
        check("midrst_drop_cnt", {24'b0, drop_cnt}, 32'h0);
`endif
        cycles(2);
        startup_seq();
        exp_q.push_back(32'h5A5A5A5A);
        send_word(32'h5A5A5A5A, 1'b1);
        cycles(1);

        // RCT failure: held word must be squashed
        word_rdy = 1'b0;
        send_word(32'h0F0F0F0F, 1'b0);
        for (int i = 0; i < 31; i++)
            send_bit(1'b1);
        check("rct_31_no_fail", {31'b0, fail}, 32'h0);
        send_bit(1'b1);
        raw_vld = 1'b0;
        check("rct_fail", {31'b0, fail}, 32'h1);
        check("rct_fail_code", {30'b0, fail_code}, 32'h1);
        check("rct_word_vld", {31'b0, word_vld}, 32'h0);
`ifdef HEALTH_STATS_EN
        check("rct_fail_cnt", {24'b0, fail_cnt}, 32'h1);
`endif
        word_rdy = 1'b1;
        cycles(3);

        clr_fail = 1'b1;
        cycles(1);
        clr_fail = 1'b0;
        check("clr_fail_flag", {30'b0, fail_code, fail}, 32'h0);

        // APT failure: 27 x (31 ones + 0) then 3 ones -> 840th one
        startup_seq();
        for (int k = 0; k < 27; k++) begin
            exp_q.push_back(32'h7FFFFFFF);
            send_word(32'h7FFFFFFF, 1'b1);
        end
        send_bit(1'b1);
        send_bit(1'b1);
        check("apt_839_no_fail", {31'b0, fail}, 32'h0);
        send_bit(1'b1);
        raw_vld = 1'b0;
        check("apt_fail", {31'b0, fail}, 32'h1);
        check("apt_fail_code", {30'b0, fail_code}, 32'h2);
`ifdef HEALTH_STATS_EN
        check("apt_fail_cnt", {24'b0, fail_cnt}, 32'h2);
`endif
        cycles(2);
        clr_fail = 1'b1;
        cycles(1);
        clr_fail = 1'b0;
        check("clr_after_apt", {30'b0, fail_code, fail}, 32'h0);

        cycles(4);
        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/entropy_health.md
ENTROPY_HEALTH -- requirements
Module: entropy_health

Interface
REQ-001 Parameter RCT_C, default 32: repetition-count cutoff; a run of RCT_C identical raw bits is a failure.
REQ-002 Parameter APT_W, default 1024: adaptive-proportion window length in raw bits.
REQ-003 Parameter APT_C, default 840: APT cutoff; APT_C occurrences of the window's first bit within one window is a failure.
REQ-004 clk  input  1  sole clock, all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  enable; low forces IDLE and discards any partial word.
REQ-007 raw_bit  input  1  raw entropy sample.
REQ-008 raw_vld  input  1  raw_bit valid this cycle; no backpressure on the raw side.
REQ-009 word_out  output  32  packed, health-checked word for the downstream trng.
REQ-010 word_vld  output  1  word_out holds an unconsumed word.
REQ-011 word_rdy  input  1  downstream accepts word_out when word_vld and word_rdy are both high.
REQ-012 fail  output  1  sticky health-test failure flag.
REQ-013 fail_code  output  2  00 none, 01 RCT, 10 APT, 11 both in the same cycle.
REQ-014 clr_fail  input  1  clears a failure and restarts the startup test.

Function
REQ-015 The FSM SHALL have states IDLE, STARTUP, RUN and FAIL.
REQ-016 IDLE SHALL go to STARTUP on the first cycle en=1.
REQ-017 STARTUP SHALL consume exactly APT_W valid bits, which are tested but never packed, then enter RUN if there is no failure.
REQ-018 Any state SHALL go to FAIL on an RCT or APT failure; the transition is in the cycle after the offending raw_vld, and fail and fail_code are registered.
REQ-019 FAIL SHALL hold until clr_fail=1, then go to STARTUP with all counters and the shifter cleared; clr_fail in other states SHALL be ignored.
REQ-020 RCT: the run counter SHALL reset to 1 when a bit differs from the previous one and otherwise increment; reaching RCT_C is a failure; the counter saturates and does not wrap.
REQ-021 APT: the first bit of each window is the reference and counts as 1; a failure occurs when the count reaches APT_C inside the window; the bit after bit APT_W starts a new window.
REQ-022 Packing (RUN only): the n-th valid bit of a word SHALL go to word_out[n], LSB first, 32 bits per word.
REQ-023 On the 32nd bit the word SHALL move to the holding register and assert word_vld the next cycle (latency 1), provided the holding register is empty or is being consumed in that same cycle.
REQ-024 Otherwise the new word SHALL be dropped and the held word kept unchanged; the shifter SHALL restart either way.
REQ-025 word_vld SHALL fall the cycle after a handshake unless a new word loads in that same cycle.
REQ-026 Entering FAIL SHALL clear word_vld and the partial word in the same cycle; a held word is never delivered after a failure.
REQ-027 raw_vld=0 cycles SHALL change no counter.

Reset
REQ-028 rst SHALL force: state IDLE, word_out=0, word_vld=0, fail=0, fail_code=00, and all counters and the shifter to 0.
REQ-029 rst SHALL take priority over en, clr_fail and raw_vld in the same cycle.
REQ-030 rst asserted mid-word SHALL discard the partial word.

Configuration
REQ-031 With HEALTH_STATS_EN defined, the block SHALL add output drop_cnt[7:0] (saturating count of dropped words) and output fail_cnt[7:0] (saturating count of FAIL entries); both are cleared only by rst.
REQ-032 Without HEALTH_STATS_EN, neither port nor its counter SHALL exist; all other behaviour is identical.

Structure
REQ-033 Package trng_pkg SHALL hold: the FSM state enum, the fail_code enum, the word width constant (32), and the default RCT_C/APT_W/APT_C constants.
REQ-034 The APT SHALL be a sub-module health_apt (inputs bit and valid, output fail), instantiated once; the RCT and packing stay in entropy_health.

Verification
REQ-035 Reset, en=1, then 1024 alternating bits followed by 32 bits of 0xA5A5A5A5 pattern LSB-first -> STARTUP ends after bit 1024; word_vld rises 1 cycle after the last bit with word_out=0xA5A5A5A5; fail stays 0.
REQ-036 In RUN, 32 consecutive 1s -> fail=1, fail_code=01 one cycle after the 32nd bit; word_vld=0.
REQ-037 A window with 840 ones and no run reaching 32 -> fail_code=10 exactly at the 840th one; clr_fail -> STARTUP with counters 0.
REQ-038 word_rdy=0 while two words complete -> the first word is held, the second dropped; with HEALTH_STATS_EN, drop_cnt=1.
REQ-039 rst pulsed after 17 bits of a word -> all outputs 0 the next cycle; the next delivered word comes only after a new STARTUP.
REQ-040 word_rdy=1 on the cycle the next word completes -> back-to-back delivery; word_vld stays high with the new value.
